// File: rtl/simd_exec_pipe_if.sv
// simd_exec_pipe_if -- bundle of every non-clock signal of simd_exec_pipe.
//   Issue side  : in_valid/in_ready handshake, operands src_a/src_b/imm,
//                 register numbers ra1/ra2/wa3, control alu_op/alu_src/
//                 reg_write/mem_write/mem_to_reg, and flush.
//   Memory side : mem_addr_c/p/m, mem_wdata, mem_we out; mem_rdata in
//                 (synchronous memory, one-cycle read latency).
//   Write-back  : wb_we, wb_wa3, wb_data toward the register file.
// The slave modport is the pipeline; the master modport is its environment.
interface simd_exec_pipe_if #(
    parameter int LANES = 3,
    parameter int DW    = 18,
    parameter int AW    = 10
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES-1:0][DW-1:0]    src_a;
    logic [LANES-1:0][DW-1:0]    src_b;
    logic [LANES-1:0][DW-1:0]    imm;
    logic [3:0]                  ra1;
    logic [3:0]                  ra2;
    logic [3:0]                  wa3;
    logic [3:0]                  alu_op;
    logic                        alu_src;
    logic                        reg_write;
    logic                        mem_write;
    logic                        mem_to_reg;
    logic                        flush;
    logic [AW-1:0]               mem_addr_c;
    logic [AW-1:0]               mem_addr_p;
    logic [AW-1:0]               mem_addr_m;
    logic [LANES-1:0][DW-1:0]    mem_wdata;
    logic                        mem_we;
    logic [LANES-1:0][DW-1:0]    mem_rdata;
    logic                        wb_we;
    logic [3:0]                  wb_wa3;
    logic [LANES-1:0][DW-1:0]    wb_data;

    modport master (
        output in_valid, src_a, src_b, imm, ra1, ra2, wa3, alu_op, alu_src,
               reg_write, mem_write, mem_to_reg, flush, mem_rdata,
        input  in_ready, mem_addr_c, mem_addr_p, mem_addr_m, mem_wdata, mem_we,
               wb_we, wb_wa3, wb_data
    );

    modport slave (
        input  in_valid, src_a, src_b, imm, ra1, ra2, wa3, alu_op, alu_src,
               reg_write, mem_write, mem_to_reg, flush, mem_rdata,
        output in_ready, mem_addr_c, mem_addr_p, mem_addr_m, mem_wdata, mem_we,
               wb_we, wb_wa3, wb_data
    );
endinterface

// File: rtl/simd_exec_pipe.sv
// simd_exec_pipe -- three-stage (E, M, W) SIMD execute pipeline.
//   CLK : single clock, rising edge.
//   RST : asynchronous, active-low reset; clears every stage.
//   bus : simd_exec_pipe_if.slave carrying issue handshake and operands,
//         memory address/data port and register-file write port.
// E holds the accepted instruction and runs the per-lane ALU with operand
// forwarding from M and W; M drives the memory port; W selects load data or
// ALU result for write-back. The only stall is a load followed directly by a
// consumer of its destination.
module simd_exec_pipe #(
    parameter int LANES  = 3,
    parameter int DW     = 18,
    parameter int AW     = 10,
    parameter int STRIDE = 1
) (
    input logic           CLK,
    input logic           RST,
    simd_exec_pipe_if.slave bus
);
    typedef logic [LANES-1:0][DW-1:0] vec_t;

    localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW] ? '1 : s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? '0 : (a - b);
    endfunction

    function automatic logic [DW-1:0] lane_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = b;
            4'd6:    r = sat_add(a, b);
            4'd7:    r = sat_sub(a, b);
            4'd8:    r = (a > b) ? a : b;
            4'd9:    r = (a < b) ? a : b;
            4'd10:   r = a >> 1;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic       vld_p0, alu_src_p0, reg_write_p0, mem_write_p0, mem_to_reg_p0;
    logic [3:0] ra1_p0, ra2_p0, wa3_p0, alu_op_p0;
    vec_t       a_p0, b_p0, imm_p0;

    logic          vld_p1, reg_write_p1, mem_write_p1, mem_to_reg_p1;
    logic [3:0]    wa3_p1;
    vec_t          res_p1, wdata_p1;
    logic [AW-1:0] addr_c_p1, addr_p_p1, addr_m_p1;

    logic       vld_p2, reg_write_p2, mem_to_reg_p2;
    logic [3:0] wa3_p2;
    vec_t       res_p2;

    logic          load_use, accept;
    vec_t          wb_data, cap_a, cap_b, fwd_a, fwd_b, opd_b, alu_res;
    logic [AW-1:0] addr_c;

    // Only a load sitting in E can hold back the next instruction.
    assign load_use = vld_p0 && mem_to_reg_p0 && (wa3_p0 == bus.ra1 || wa3_p0 == bus.ra2);
    assign accept   = bus.in_valid && !load_use && !bus.flush;
    assign wb_data  = mem_to_reg_p2 ? bus.mem_rdata : res_p2;

    // A register written by W on the capture edge is not yet visible in the
    // operands the register file presents, so take it from wb_data instead.
    assign cap_a = (vld_p2 && reg_write_p2 && wa3_p2 == bus.ra1) ? wb_data : bus.src_a;
    assign cap_b = (vld_p2 && reg_write_p2 && wa3_p2 == bus.ra2) ? wb_data : bus.src_b;

    always_comb begin
        fwd_a = a_p0;
        if (vld_p1 && reg_write_p1 && !mem_to_reg_p1 && wa3_p1 == ra1_p0)
            fwd_a = res_p1;
        else if (vld_p2 && reg_write_p2 && wa3_p2 == ra1_p0)
            fwd_a = wb_data;
        fwd_b = b_p0;
        if (vld_p1 && reg_write_p1 && !mem_to_reg_p1 && wa3_p1 == ra2_p0)
            fwd_b = res_p1;
        else if (vld_p2 && reg_write_p2 && wa3_p2 == ra2_p0)
            fwd_b = wb_data;
    end

    assign opd_b = alu_src_p0 ? imm_p0 : fwd_b;

    always_comb begin
        alu_res = '0;
        for (int l = 0; l < LANES; l++)
            alu_res[l] = lane_alu(alu_op_p0, fwd_a[l], opd_b[l]);
    end

    assign addr_c = alu_res[0][AW-1:0];

    // E stage: capture on accept, otherwise a bubble with enables cleared.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p0        <= 1'b0;
            reg_write_p0  <= 1'b0;
            mem_write_p0  <= 1'b0;
            mem_to_reg_p0 <= 1'b0;
            alu_src_p0    <= 1'b0;
            alu_op_p0     <= '0;
            ra1_p0        <= '0;
            ra2_p0        <= '0;
            wa3_p0        <= '0;
            a_p0          <= '0;
            b_p0          <= '0;
            imm_p0        <= '0;
        end else begin
            vld_p0        <= accept;
            reg_write_p0  <= accept && bus.reg_write;
            mem_write_p0  <= accept && bus.mem_write;
            mem_to_reg_p0 <= accept && bus.mem_to_reg;
            alu_src_p0    <= bus.alu_src;
            alu_op_p0     <= bus.alu_op;
            ra1_p0        <= bus.ra1;
            ra2_p0        <= bus.ra2;
            wa3_p0        <= bus.wa3;
            a_p0          <= cap_a;
            b_p0          <= cap_b;
            imm_p0        <= bus.imm;
        end
    end

    // M stage: flush squashes the instruction leaving E.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            wa3_p1        <= '0;
            res_p1        <= '0;
            wdata_p1      <= '0;
            addr_c_p1     <= '0;
            addr_p_p1     <= '0;
            addr_m_p1     <= '0;
        end else begin
            vld_p1        <= vld_p0 && !bus.flush;
            reg_write_p1  <= reg_write_p0 && !bus.flush;
            mem_write_p1  <= mem_write_p0 && !bus.flush;
            mem_to_reg_p1 <= mem_to_reg_p0;
            wa3_p1        <= wa3_p0;
            res_p1        <= alu_res;
            wdata_p1      <= fwd_b;
            addr_c_p1     <= addr_c;
            addr_p_p1     <= addr_c + STRIDE_A;
            addr_m_p1     <= addr_c - STRIDE_A;
        end
    end

    // W stage: load data arrives from memory during this stage.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p2        <= 1'b0;
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
            wa3_p2        <= '0;
            res_p2        <= '0;
        end else begin
            vld_p2        <= vld_p1;
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
            wa3_p2        <= wa3_p1;
            res_p2        <= res_p1;
        end
    end

    assign bus.in_ready   = !load_use;
    assign bus.mem_addr_c = addr_c_p1;
    assign bus.mem_addr_p = addr_p_p1;
    assign bus.mem_addr_m = addr_m_p1;
    assign bus.mem_wdata  = wdata_p1;
    assign bus.mem_we     = vld_p1 && mem_write_p1;
    assign bus.wb_we      = vld_p2 && reg_write_p2;
    assign bus.wb_wa3     = wa3_p2;
    assign bus.wb_data    = wb_data;
endmodule

// File: tb/tb_simd_exec_pipe.sv
// tb_simd_exec_pipe -- bench for simd_exec_pipe: table-driven ALU vectors,
// hand-written hazard/flush/reset/store sequences and randomized instruction
// streams compared against an architectural model (register array + memory
// array executed one instruction at a time in program order).
module tb_simd_exec_pipe;
    localparam int LANES = 3, DW = 18, AW = 10, STRIDE = 1;
    localparam int MEMN = 1 << AW;

    typedef logic [LANES-1:0][DW-1:0] vec_t;
    typedef struct { logic [3:0] wa; vec_t d; } wb_t;
    typedef struct { logic [AW-1:0] a; vec_t d; } st_t;
    typedef struct { logic [3:0] op; vec_t a; vec_t b; vec_t exp; } vrec_t;
    typedef struct {
        logic [3:0] op, r1, r2, wa;
        vec_t       imm;
        logic       asrc, rw, mw, m2r;
    } ins_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    simd_exec_pipe_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();
    simd_exec_pipe #(.LANES(LANES), .DW(DW), .AW(AW), .STRIDE(STRIDE)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    function automatic vec_t init_reg(input int i);
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = DW'(i * 7 + l * 3 + 1);
        return v;
    endfunction

    // Environment: register file and synchronous memory around the pipe.
    vec_t rf [16];
    vec_t mem[MEMN];
    always @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) rf[i] <= init_reg(i);
            for (int j = 0; j < MEMN; j++) mem[j] <= '0;
            bus.mem_rdata <= '0;
        end else begin
            if (bus.wb_we) rf[bus.wb_wa3] <= bus.wb_data;
            if (bus.mem_we) mem[bus.mem_addr_c] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr_c];
        end
    end

    // Reference model state.
    vec_t mrf [16];
    vec_t mmem[MEMN];
    wb_t  exp_q[$];
    st_t  st_q[$];
    logic prev_load;
    logic [3:0] prev_wa;
    int n_chk, n_fail;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mrf[i] = init_reg(i);
        for (int j = 0; j < MEMN; j++) mmem[j] = '0;
        exp_q.delete();
        st_q.delete();
        prev_load = 1'b0;
        prev_wa = '0;
    endtask

    function automatic logic [DW-1:0] ref_lane(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        longint ua, ub, mx, r;
        ua = longint'(a);
        ub = longint'(b);
        mx = (longint'(1) << DW) - 1;
        case (op)
            4'd0:    r = (ua + ub) & mx;
            4'd1:    r = (ua - ub) & mx;
            4'd2:    r = ua & ub;
            4'd3:    r = ua | ub;
            4'd4:    r = ua ^ ub;
            4'd5:    r = ub;
            4'd6:    r = (ua + ub > mx) ? mx : ua + ub;
            4'd7:    r = (ua > ub) ? ua - ub : 0;
            4'd8:    r = (ua > ub) ? ua : ub;
            4'd9:    r = (ua < ub) ? ua : ub;
            4'd10:   r = ua / 2;
            default: r = 0;
        endcase
        return DW'(r);
    endfunction

    function automatic vec_t mkv(input int x0, input int x1, input int x2);
        vec_t v;
        v[0] = DW'(x0);
        v[1] = DW'(x1);
        v[2] = DW'(x2);
        return v;
    endfunction

    function automatic ins_t mki(input int op, input int r1, input int r2, input int wa,
                                 input vec_t imm, input logic asrc, input logic rw,
                                 input logic mw, input logic m2r);
        ins_t i;
        i.op = 4'(op); i.r1 = 4'(r1); i.r2 = 4'(r2); i.wa = 4'(wa);
        i.imm = imm; i.asrc = asrc; i.rw = rw; i.mw = mw; i.m2r = m2r;
        return i;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Advance one clock; compare any write-back or store against the model.
    task automatic cyc();
        wb_t e;
        st_t s;
        @(negedge CLK);
        if (bus.wb_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: wa3=%0d data=%0h, no write required", bus.wb_wa3, bus.wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_wa3", 128'(bus.wb_wa3), 128'(e.wa));
                chk("wb_data", 128'(bus.wb_data), 128'(e.d));
            end
        end
        if (bus.mem_we) begin
            if (st_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL st_unexpected: addr=%0h data=%0h, no store required", bus.mem_addr_c, bus.mem_wdata);
            end else begin
                s = st_q.pop_front();
                chk("st_addr_c", 128'(bus.mem_addr_c), 128'(s.a));
                chk("st_addr_p", 128'(bus.mem_addr_p), 128'(AW'(s.a + AW'(STRIDE))));
                chk("st_addr_m", 128'(bus.mem_addr_m), 128'(AW'(s.a - AW'(STRIDE))));
                chk("st_wdata", 128'(bus.mem_wdata), 128'(s.d));
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int k = 0; k < n; k++) cyc();
        prev_load = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int t = 0; t < 8 && (exp_q.size() != 0 || st_q.size() != 0); t++) cyc();
        prev_load = 1'b0;
        chk("drain_wb", 128'(exp_q.size()), 128'(0));
        chk("drain_st", 128'(st_q.size()), 128'(0));
    endtask

    // Present one instruction (called at a falling edge) until accepted.
    task automatic issue(input ins_t in, input logic use_exp, input vec_t expv,
                         input logic squash, output int stalls);
        int want;
        vec_t a, b, bo, res, old;
        logic [AW-1:0] ad;
        wb_t e;
        st_t s;
        want = (prev_load && (prev_wa == in.r1 || prev_wa == in.r2)) ? 1 : 0;
        stalls = 0;
        bus.alu_op = in.op; bus.ra1 = in.r1; bus.ra2 = in.r2; bus.wa3 = in.wa;
        bus.imm = in.imm; bus.alu_src = in.asrc; bus.reg_write = in.rw;
        bus.mem_write = in.mw; bus.mem_to_reg = in.m2r; bus.in_valid = 1'b1;
        bus.src_a = rf[in.r1]; bus.src_b = rf[in.r2];
        #1;
        while (!bus.in_ready && stalls < 4) begin
            cyc();
            stalls++;
            bus.src_a = rf[in.r1]; bus.src_b = rf[in.r2];
            #1;
        end
        chk("stall_cycles", 128'(stalls), 128'(want));
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            prev_load = 1'b0;
            return;
        end
        if (!squash) begin
            a = mrf[in.r1];
            b = mrf[in.r2];
            bo = in.asrc ? in.imm : b;
            for (int l = 0; l < LANES; l++) res[l] = ref_lane(in.op, a[l], bo[l]);
            ad = res[0][AW-1:0];
            old = mmem[ad];
            if (in.mw) begin
                s.a = ad; s.d = b;
                st_q.push_back(s);
                mmem[ad] = b;
            end
            if (in.rw) begin
                e.wa = in.wa;
                e.d = in.m2r ? old : res;
                mrf[in.wa] = e.d;
                if (use_exp) e.d = expv;
                exp_q.push_back(e);
            end
        end
        cyc();
        bus.in_valid = 1'b0;
        prev_load = squash ? 1'b0 : in.m2r;
        prev_wa = in.wa;
        if (squash) begin
            bus.flush = 1'b1;
            cyc();
            bus.flush = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        chk({tag, "_mem_we"}, 128'(bus.mem_we), 128'(0));
        chk({tag, "_wb_we"}, 128'(bus.wb_we), 128'(0));
        chk({tag, "_wb_data"}, 128'(bus.wb_data), 128'(0));
        chk({tag, "_mem_wdata"}, 128'(bus.mem_wdata), 128'(0));
        chk({tag, "_addr_c"}, 128'(bus.mem_addr_c), 128'(0));
        chk({tag, "_addr_p"}, 128'(bus.mem_addr_p), 128'(0));
        chk({tag, "_addr_m"}, 128'(bus.mem_addr_m), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vrec_t tbl[13];
    vec_t  z;

    initial begin
        int st;
        ins_t ri;
        n_chk = 0;
        n_fail = 0;
        z = '0;
        bus.in_valid = 0; bus.src_a = '0; bus.src_b = '0; bus.imm = '0;
        bus.ra1 = '0; bus.ra2 = '0; bus.wa3 = '0; bus.alu_op = '0; bus.alu_src = 0;
        bus.reg_write = 0; bus.mem_write = 0; bus.mem_to_reg = 0; bus.flush = 0;
        model_reset();

        tbl[0]  = '{4'd0,  mkv(5, 6, 7),                 mkv(1, 1, 1),          mkv(6, 7, 8)};
        tbl[1]  = '{4'd1,  mkv(1, 2, 3),                 mkv(2, 2, 2),          mkv('h3FFFF, 0, 1)};
        tbl[2]  = '{4'd2,  mkv('hFF, 3, 5),              mkv('h0F, 1, 4),       mkv('h0F, 1, 4)};
        tbl[3]  = '{4'd3,  mkv('hF0, 1, 0),              mkv('h0F, 2, 0),       mkv('hFF, 3, 0)};
        tbl[4]  = '{4'd4,  mkv('hFF, 3, 5),              mkv('h0F, 1, 5),       mkv('hF0, 2, 0)};
        tbl[5]  = '{4'd5,  mkv(9, 9, 9),                 mkv(1, 2, 3),          mkv(1, 2, 3)};
        tbl[6]  = '{4'd6,  mkv('h3FFFF, 10, 'h3FFFA),    mkv(5, 5, 5),          mkv('h3FFFF, 15, 'h3FFFF)};
        tbl[7]  = '{4'd7,  mkv(2, 9, 9),                 mkv(9, 2, 9),          mkv(0, 7, 0)};
        tbl[8]  = '{4'd8,  mkv(5, 100, 7),               mkv(6, 3, 7),          mkv(6, 100, 7)};
        tbl[9]  = '{4'd9,  mkv(5, 100, 7),               mkv(6, 3, 7),          mkv(5, 3, 7)};
        tbl[10] = '{4'd10, mkv(5, 'h3FFFF, 'h20000),     mkv(0, 0, 0),          mkv(2, 'h1FFFF, 'h10000)};
        tbl[11] = '{4'd11, mkv(5, 6, 7),                 mkv(1, 1, 1),          mkv(0, 0, 0)};
        tbl[12] = '{4'd15, mkv(5, 6, 7),                 mkv(1, 1, 1),          mkv(0, 0, 0)};

        // Power-on reset.
        @(negedge CLK);
        @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b1;
        idle(1);

        // ADD r1 = {5,6,7} + imm 1: three-edge latency, then M-forwarded r2 = r1 + r1.
        issue(mki(5, 0, 0, 10, mkv(5, 6, 7), 1, 1, 0, 0), 0, z, 0, st);
        drain();
        issue(mki(0, 10, 0, 1, mkv(1, 1, 1), 1, 1, 0, 0), 1, mkv(6, 7, 8), 0, st);
        chk("lat_e_wb_we", 128'(bus.wb_we), 128'(0));
        issue(mki(0, 1, 1, 2, z, 0, 1, 0, 0), 1, mkv(12, 14, 16), 0, st);
        chk("b2b_stall", 128'(st), 128'(0));
        chk("lat_m_wb_we", 128'(bus.wb_we), 128'(0));
        cyc();
        chk("lat_w_wb_we", 128'(bus.wb_we), 128'(1));
        chk("lat_w_wa3", 128'(bus.wb_wa3), 128'(1));
        drain();

        // ALU vector table, each operation fed through M forwarding.
        for (int v = 0; v < 13; v++) begin
            issue(mki(5, 0, 0, 1, tbl[v].a, 1, 1, 0, 0), 0, z, 0, st);
            issue(mki(int'(tbl[v].op), 1, 0, 2, tbl[v].b, 1, 1, 0, 0), 1, tbl[v].exp, 0, st);
        end
        drain();

        // Store, load, then a dependent SUB on the loaded register.
        issue(mki(5, 0, 0, 7, mkv(11, 22, 33), 1, 1, 0, 0), 0, z, 0, st);
        issue(mki(5, 0, 0, 9, mkv(1, 2, 3), 1, 1, 0, 0), 0, z, 0, st);
        issue(mki(5, 0, 7, 0, mkv(20, 0, 0), 1, 0, 1, 0), 0, z, 0, st);
        issue(mki(5, 0, 0, 3, mkv(20, 0, 0), 1, 1, 0, 1), 1, mkv(11, 22, 33), 0, st);
        issue(mki(1, 3, 9, 8, z, 0, 1, 0, 0), 1, mkv(10, 20, 30), 0, st);
        chk("load_use_stall", 128'(st), 128'(1));
        drain();

        // Store with lane-0 result 0: address wrap and one-cycle mem_we.
        issue(mki(5, 0, 7, 0, mkv(0, 5, 5), 1, 0, 1, 0), 0, z, 0, st);
        chk("st_e_mem_we", 128'(bus.mem_we), 128'(0));
        cyc();
        chk("st_m_mem_we", 128'(bus.mem_we), 128'(1));
        chk("st_addr_c0", 128'(bus.mem_addr_c), 128'(0));
        chk("st_addr_p1", 128'(bus.mem_addr_p), 128'(1));
        chk("st_addr_m1023", 128'(bus.mem_addr_m), 128'(1023));
        cyc();
        chk("st_w_mem_we", 128'(bus.mem_we), 128'(0));
        drain();

        // Flush of a lone reg_write instruction in E.
        issue(mki(0, 1, 1, 4, z, 0, 1, 0, 0), 0, z, 1, st);
        for (int k = 0; k < 4; k++) begin
            chk("flush_wb_we", 128'(bus.wb_we), 128'(0));
            cyc();
        end
        // Flush with an older instruction ahead: the older one still writes back.
        issue(mki(5, 0, 0, 5, mkv(3, 4, 5), 1, 1, 0, 0), 0, z, 0, st);
        issue(mki(0, 5, 5, 6, z, 0, 1, 0, 0), 0, z, 1, st);
        drain();
        issue(mki(0, 4, 6, 11, z, 0, 1, 0, 0), 0, z, 0, st);
        drain();

        // Randomized stream against the model.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                ri.op = 4'($urandom_range(0, 15));
                ri.r1 = 4'($urandom_range(0, 3));
                ri.r2 = 4'($urandom_range(0, 3));
                ri.wa = 4'($urandom_range(0, 3));
                for (int l = 0; l < LANES; l++) ri.imm[l] = DW'($urandom);
                ri.asrc = 1'($urandom_range(0, 1));
                ri.rw = ($urandom_range(0, 3) != 0);
                ri.mw = ($urandom_range(0, 3) == 0);
                ri.m2r = ($urandom_range(0, 3) == 0);
                issue(ri, 0, z, 0, st);
            end
        end
        drain();

        // Reset pulse with instructions in flight: none may write back.
        issue(mki(0, 1, 2, 1, z, 0, 1, 0, 0), 0, z, 0, st);
        issue(mki(5, 0, 2, 2, mkv(7, 0, 0), 1, 1, 1, 0), 0, z, 0, st);
        RST = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        cyc();
        chk("rst_wb_we", 128'(bus.wb_we), 128'(0));
        cyc();
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("post_rst_wb_we", 128'(bus.wb_we), 128'(0));
            chk("post_rst_mem_we", 128'(bus.mem_we), 128'(0));
        end
        for (int k = 0; k < 80; k++) begin
            ri.op = 4'($urandom_range(0, 10));
            ri.r1 = 4'($urandom_range(0, 2));
            ri.r2 = 4'($urandom_range(0, 2));
            ri.wa = 4'($urandom_range(0, 2));
            for (int l = 0; l < LANES; l++) ri.imm[l] = DW'($urandom);
            ri.asrc = 1'($urandom_range(0, 1));
            ri.rw = 1'b1;
            ri.mw = ($urandom_range(0, 4) == 0);
            ri.m2r = ($urandom_range(0, 3) == 0);
            issue(ri, 0, z, 0, st);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
